// File: rtl/q_updater_multi_if.sv
// q_updater_multi_if: sample bus (in_valid, q_cur, q_next, r, a, amax, alpha, gamma) and result bus (out_valid, qnew, a_out, amax_out, ovf)
interface q_updater_multi_if #(
  parameter int DW = 32,
  parameter int NACT = 4,
  parameter int NAG = 2
);
  localparam int AW = $clog2(NACT);
  logic in_valid;
  logic [NAG*NACT*DW-1:0] q_cur;
  logic [NAG*NACT*DW-1:0] q_next;
  logic [DW-1:0] r;
  logic [NAG*AW-1:0] a;
  logic [NAG*AW-1:0] amax;
  logic [2:0] alpha;
  logic [2:0] gamma;
  logic out_valid;
  logic [NAG*DW-1:0] qnew;
  logic [NAG*AW-1:0] a_out;
  logic [NAG*AW-1:0] amax_out;
  logic [NAG-1:0] ovf;
  modport master (
    output in_valid, q_cur, q_next, r, a, amax, alpha, gamma,
    input out_valid, qnew, a_out, amax_out, ovf
  );
  modport slave (
    input in_valid, q_cur, q_next, r, a, amax, alpha, gamma,
    output out_valid, qnew, a_out, amax_out, ovf
  );
endinterface

// File: rtl/q_updater_multi.sv
// q_updater_multi: 5-stage per-agent Bellman Q update; ports clk, rst (sync high), bus (slave: samples in, qnew/a_out/amax_out/ovf out)
module q_updater_multi #(
  parameter int DW = 32,
  parameter int NACT = 4,
  parameter int NAG = 2,
  parameter int SAT = 1,
  parameter int MAX_MODE = 0
) (
  input logic clk,
  input logic rst,
  q_updater_multi_if.slave bus
);
  localparam int AW = $clog2(NACT);
  localparam int W2 = DW + 2;
  localparam int W3 = DW + 3;
  localparam logic [DW-1:0] QMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] QMIN = {1'b1, {(DW-1){1'b0}}};
  logic v1, v2, v3, v4;
  logic signed [DW-1:0] qc1 [NAG][NACT];
  logic signed [DW-1:0] qn1 [NAG][NACT];
  logic signed [DW-1:0] r1, r2;
  logic [2:0] al1, al2, al3, ga1;
  logic [AW-1:0] a1 [NAG], a2 [NAG], a3 [NAG], a4 [NAG];
  logic [AW-1:0] am1 [NAG], im2 [NAG], im3 [NAG], im4 [NAG];
  logic signed [DW-1:0] qs2 [NAG], qs3 [NAG], qs4 [NAG], g2 [NAG];
  logic signed [W2-1:0] d3 [NAG], p4 [NAG];
  logic [AW-1:0] im_c [NAG];
  logic signed [DW-1:0] qsel_c [NAG], g_c [NAG];
  logic signed [W2-1:0] d_c [NAG];
  logic signed [W3-1:0] s_c [NAG];
  logic [NAG-1:0] ovf_c;
  function automatic logic [AW-1:0] argmax(input logic signed [DW-1:0] q [NACT]);
    logic [AW-1:0] b;
    b = '0;
    for (int k = 1; k < NACT; k++) if (q[k] > q[b]) b = AW'(k);
    return b;
  endfunction
  always_comb begin
    ovf_c = '0;
    for (int g = 0; g < NAG; g++) begin
      im_c[g] = MAX_MODE != 0 ? argmax(qn1[g]) : am1[g];
      qsel_c[g] = qc1[g][a1[g]];
      g_c[g] = qn1[g][im_c[g]] >>> ga1;
      d_c[g] = W2'(r2) - W2'(qs2[g]) + W2'(g2[g]);
      s_c[g] = W3'(qs4[g]) + W3'(p4[g]);
      ovf_c[g] = !(&s_c[g][W3-1:DW-1] || ~|s_c[g][W3-1:DW-1]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, v3, v4} <= '0;
      bus.out_valid <= 1'b0;
      bus.qnew <= '0;
      bus.a_out <= '0;
      bus.amax_out <= '0;
      bus.ovf <= '0;
    end else begin
      {v1, v2, v3, v4} <= {bus.in_valid, v1, v2, v3};
      bus.out_valid <= v4;
      if (v4)
        for (int g = 0; g < NAG; g++) begin
          bus.qnew[g*DW +: DW] <= (SAT != 0 && ovf_c[g]) ? (s_c[g][W3-1] ? QMIN : QMAX) : s_c[g][DW-1:0];
          bus.a_out[g*AW +: AW] <= a4[g];
          bus.amax_out[g*AW +: AW] <= im4[g];
          bus.ovf[g] <= ovf_c[g];
        end
    end
    r1 <= bus.r;
    al1 <= bus.alpha;
    ga1 <= bus.gamma;
    r2 <= r1;
    al2 <= al1;
    al3 <= al2;
    for (int g = 0; g < NAG; g++) begin
      for (int k = 0; k < NACT; k++) begin
        qc1[g][k] <= bus.q_cur[(g*NACT+k)*DW +: DW];
        qn1[g][k] <= bus.q_next[(g*NACT+k)*DW +: DW];
      end
      a1[g] <= bus.a[g*AW +: AW];
      am1[g] <= bus.amax[g*AW +: AW];
      qs2[g] <= qsel_c[g];
      g2[g] <= g_c[g];
      a2[g] <= a1[g];
      im2[g] <= im_c[g];
      d3[g] <= d_c[g];
      qs3[g] <= qs2[g];
      a3[g] <= a2[g];
      im3[g] <= im2[g];
      p4[g] <= d3[g] >>> al3;
      qs4[g] <= qs3[g];
      a4[g] <= a3[g];
      im4[g] <= im3[g];
    end
  end
endmodule

// File: tb/tb_q_updater_multi.sv
// tb_q_updater_multi: scoreboard bench driving three variants (MAX_MODE=0/SAT=1, MAX_MODE=1/SAT=1, MAX_MODE=0/SAT=0) with one stimulus
module tb_q_updater_multi;
  localparam int DW = 32;
  localparam int NACT = 4;
  localparam int NAG = 2;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0;
  int checks = 0;
  logic in_valid = 1'b0;
  int qc [NAG][NACT];
  int qn [NAG][NACT];
  int ra;
  logic [AW-1:0] aa [NAG];
  logic [AW-1:0] ama [NAG];
  logic [2:0] al, ga;
  logic [NAG*NACT*DW-1:0] qc_bus, qn_bus;
  logic [NAG*AW-1:0] a_bus, am_bus;
  always_comb begin
    qc_bus = '0;
    qn_bus = '0;
    a_bus = '0;
    am_bus = '0;
    for (int g = 0; g < NAG; g++) begin
      for (int k = 0; k < NACT; k++) begin
        qc_bus[(g*NACT+k)*DW +: DW] = qc[g][k];
        qn_bus[(g*NACT+k)*DW +: DW] = qn[g][k];
      end
      a_bus[g*AW +: AW] = aa[g];
      am_bus[g*AW +: AW] = ama[g];
    end
  end
  logic [2:0] ov_v;
  logic [2:0][NAG*DW-1:0] qn_o;
  logic [2:0][NAG*AW-1:0] a_o, am_o;
  logic [2:0][NAG-1:0] ovf_o;
  for (genvar i = 0; i < 3; i++) begin : v
    q_updater_multi_if #(.DW(DW), .NACT(NACT), .NAG(NAG)) bus ();
    assign bus.in_valid = in_valid;
    assign bus.q_cur = qc_bus;
    assign bus.q_next = qn_bus;
    assign bus.r = ra;
    assign bus.a = a_bus;
    assign bus.amax = am_bus;
    assign bus.alpha = al;
    assign bus.gamma = ga;
    assign ov_v[i] = bus.out_valid;
    assign qn_o[i] = bus.qnew;
    assign a_o[i] = bus.a_out;
    assign am_o[i] = bus.amax_out;
    assign ovf_o[i] = bus.ovf;
    q_updater_multi #(.DW(DW), .NACT(NACT), .NAG(NAG), .SAT(i == 2 ? 0 : 1), .MAX_MODE(i == 1 ? 1 : 0)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end
  typedef struct {
    int due;
    logic [2:0][NAG-1:0][DW-1:0] q;
    logic [2:0][NAG-1:0][AW-1:0] am;
    logic [2:0][NAG-1:0] ov;
    logic [NAG-1:0][AW-1:0] a;
  } exp_t;
  exp_t sb [$];
  function automatic void model(input int g, input bit mode, input bit sat, output logic [DW-1:0] q, output logic [AW-1:0] im, output logic ov);
    longint qsel, qmax, gg, d, p, s;
    int b;
    b = mode ? 0 : int'(ama[g]);
    if (mode) for (int k = 1; k < NACT; k++) if (qn[g][k] > qn[g][b]) b = k;
    qsel = qc[g][aa[g]];
    qmax = qn[g][b];
    gg = qmax >>> ga;
    d = ra - qsel + gg;
    p = d >>> al;
    s = qsel + p;
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    q = (ov && sat) ? (s < 0 ? 32'h80000000 : 32'h7fffffff) : s[31:0];
    im = AW'(b);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    bit due;
    due = sb.size() > 0 && sb[0].due == cyc;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov_v[i] !== due) begin
        errors++;
        $display("FAIL out_valid dut%0d cyc%0d: got %b want %b", i, cyc, ov_v[i], due);
      end
    end
    if (due) begin
      e = sb.pop_front();
      for (int i = 0; i < 3; i++)
        for (int g = 0; g < NAG; g++) begin
          checks++;
          if ({qn_o[i][g*DW +: DW], a_o[i][g*AW +: AW], am_o[i][g*AW +: AW], ovf_o[i][g]} !== {e.q[i][g], e.a[g], e.am[i][g], e.ov[i][g]}) begin
            errors++;
            $display("FAIL result dut%0d agent%0d cyc%0d: got q=%h a=%0d am=%0d ovf=%b want q=%h a=%0d am=%0d ovf=%b", i, g, cyc,
              qn_o[i][g*DW +: DW], a_o[i][g*AW +: AW], am_o[i][g*AW +: AW], ovf_o[i][g], e.q[i][g], e.a[g], e.am[i][g], e.ov[i][g]);
          end
        end
    end
  end
  task automatic set_zero();
    for (int g = 0; g < NAG; g++) begin
      for (int k = 0; k < NACT; k++) begin
        qc[g][k] = 0;
        qn[g][k] = 0;
      end
      aa[g] = '0;
      ama[g] = '0;
    end
    ra = 0;
    al = '0;
    ga = '0;
  endtask
  task automatic issue(input logic vin);
    exp_t e;
    in_valid = vin;
    if (vin && !rst) begin
      e.due = cyc + 5;
      for (int i = 0; i < 3; i++)
        for (int g = 0; g < NAG; g++) model(g, i == 1, i != 2, e.q[i][g], e.am[i][g], e.ov[i][g]);
      for (int g = 0; g < NAG; g++) e.a[g] = aa[g];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs missing want 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ov_v[i], qn_o[i], a_o[i], am_o[i], ovf_o[i]} !== '0) begin
        errors++;
        $display("FAIL %s dut%0d: got valid=%b q=%h a=%h am=%h ovf=%b want all 0", name, i, ov_v[i], qn_o[i], a_o[i], am_o[i], ovf_o[i]);
      end
    end
  endtask
  task automatic test_reset();
    set_zero();
    ra = 5;
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    set_zero();
    qc[0] = '{10, 20, 30, 40};
    qn[0] = '{0, 100, 50, 8};
    aa[0] = 2;
    ama[0] = 1;
    qc[1] = '{-5, 7, 100, -100};
    qn[1] = '{1, 2, 3, 4};
    aa[1] = 3;
    ama[1] = 0;
    ra = 20;
    ga = 1;
    al = 2;
    issue(1'b1);
    drain();
    checks++;
    if ({qn_o[0][DW-1:0], a_o[0][AW-1:0], am_o[0][AW-1:0], ovf_o[0][0]} !== {32'd40, 2'd2, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL basic: got q=%0d a=%0d am=%0d ovf=%b want q=40 a=2 am=1 ovf=0", $signed(qn_o[0][DW-1:0]), a_o[0][AW-1:0], am_o[0][AW-1:0], ovf_o[0][0]);
    end
  endtask
  task automatic test_argmax();
    set_zero();
    qn[0] = '{5, -3, 9, 9};
    ama[0] = 1;
    qn[1] = '{-10, -20, -5, -30};
    ama[1] = 3;
    issue(1'b1);
    drain();
    checks++;
    if ({qn_o[1][DW-1:0], am_o[1][AW-1:0]} !== {32'd9, 2'd2}) begin
      errors++;
      $display("FAIL argmax: got q=%0d am=%0d want q=9 am=2", $signed(qn_o[1][DW-1:0]), am_o[1][AW-1:0]);
    end
  endtask
  task automatic test_round();
    set_zero();
    ra = -7;
    al = 1;
    qc[1][0] = 3;
    issue(1'b1);
    drain();
    checks++;
    if (qn_o[0][DW-1:0] !== 32'hfffffffc) begin
      errors++;
      $display("FAIL round: got q=%0d want -4", $signed(qn_o[0][DW-1:0]));
    end
  endtask
  task automatic test_sat();
    set_zero();
    ra = int'(32'h80000000);
    qn[0][0] = int'(32'h80000000);
    qn[1][0] = 12345;
    issue(1'b1);
    qc[0][0] = int'(32'h7fffff00);
    ra = int'(32'h7fffffff);
    qn[0][0] = int'(32'h7fffffff);
    issue(1'b1);
    drain();
    checks++;
    if ({qn_o[0][DW-1:0], ovf_o[0][0], qn_o[2][DW-1:0], ovf_o[2][0]} !== {32'h7fffffff, 1'b1, 32'hfffffffe, 1'b1}) begin
      errors++;
      $display("FAIL sat: got clamp=%h ovf=%b wrap=%h ovf=%b want 7fffffff 1 fffffffe 1", qn_o[0][DW-1:0], ovf_o[0][0], qn_o[2][DW-1:0], ovf_o[2][0]);
    end
  endtask
  task automatic test_stream();
    set_zero();
    ra = 1;
    issue(1'b1);
    ra = 2;
    issue(1'b1);
    ra = 3;
    issue(1'b0);
    ra = 4;
    issue(1'b1);
    drain();
    checks++;
    if (qn_o[0][DW-1:0] !== 32'd4) begin
      errors++;
      $display("FAIL stream_last: got q=%0d want 4", qn_o[0][DW-1:0]);
    end
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < NAG; g++) begin
        for (int k = 0; k < NACT; k++) begin
          qc[g][k] = int'($urandom());
          qn[g][k] = (n % 2 == 0) ? int'($urandom()) : $urandom_range(0, 200) - 100;
        end
        aa[g] = AW'($urandom_range(0, NACT - 1));
        ama[g] = AW'($urandom_range(0, NACT - 1));
      end
      ra = int'($urandom());
      al = 3'($urandom_range(0, 7));
      ga = 3'($urandom_range(0, 7));
      issue($urandom_range(0, 3) != 0);
    end
    drain();
  endtask
  task automatic test_reset_midflight();
    set_zero();
    ra = 11;
    issue(1'b1);
    ra = 12;
    issue(1'b1);
    ra = 13;
    rst = 1'b1;
    sb.delete();
    issue(1'b1);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check_zero("midflight_reset");
    end
    @(posedge clk);
    #1;
    ra = 21;
    issue(1'b1);
    drain();
    checks++;
    if (qn_o[0][DW-1:0] !== 32'd21) begin
      errors++;
      $display("FAIL after_reset: got q=%0d want 21", qn_o[0][DW-1:0]);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_argmax();
    test_round();
    test_sat();
    test_stream();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/q_updater_multi.md
Name: q_updater_multi

Overview:
- Pipelined Bellman Q-learning update engine for NAG independent agents, each with NACT actions.
- Computes Qnew = Qsel + alpha*(R + gamma*Qmax - Qsel) per agent every cycle: alpha and gamma are right-shift weights, arithmetic is signed two's complement.
- Sits between the Q-table read ports and the Q-table write port in the traffic-intersection learning loop.
- Replaces the fixed dual-agent updater. Adds:
  - separate current-state and next-state Q inputs, so there is no implicit time skew;
  - a valid pipeline;
  - an optional internal argmax;
  - saturation with an overflow flag.

Parameters:
DW, 32, Q-value and reward width (signed)
NACT, 4, actions per agent (power of 2, >=2); AW = clog2(NACT)
NAG, 2, number of agents
SAT, 1, 1 = clamp result to signed DW range; 0 = wrap
MAX_MODE, 0, 0 = use amax input; 1 = compute argmax of q_next internally

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  sample present on inputs this cycle
q_cur  in  NAG*NACT*DW  Q(s,·) per agent; agent g action k at [(g*NACT+k)*DW +: DW]
q_next  in  NAG*NACT*DW  Q(s',·) per agent, same packing
r  in  DW  reward, shared by all agents
a  in  NAG*AW  action taken per agent
amax  in  NAG*AW  greedy action in s' per agent (ignored when MAX_MODE=1)
alpha  in  3  learning-rate shift: alpha*x = x >>> alpha
gamma  in  3  discount shift: gamma*x = x >>> gamma
out_valid  out  1  qnew/a_out valid
qnew  out  NAG*DW  updated Q(s,a) per agent
a_out  out  NAG*AW  action index aligned with qnew (write address)
amax_out  out  NAG*AW  argmax index used (input or internal)
ovf  out  NAG  per-agent overflow flag, aligned with qnew

Behaviour:
- Interface: one clock clk, reset rst synchronous active-high. All state changes on posedge clk only.
- Reset: all valid bits cleared; out_valid, qnew, a_out, amax_out, ovf = 0.
  - In-flight samples are dropped.
  - in_valid asserted in a cycle with rst=1 is ignored.
- Throughput and latency:
  - Fully pipelined: one sample per cycle, no backpressure.
  - Fixed latency 5 cycles: a sample with in_valid at posedge N gives out_valid=1 at posedge N+5.
  - Data registers hold their last value when out_valid=0. Only out_valid qualifies outputs.
- alpha, gamma, r, a and amax are captured with the sample in S1 and travel with it. Changing them mid-stream affects only later samples.
- Pipeline, per agent in parallel:
  - S1: register all inputs plus valid.
  - S2: Qsel = q_cur[a]. Qmax = q_next[amax] (MAX_MODE=0) or max over q_next (MAX_MODE=1; signed compare, tie -> lowest index). G = Qmax >>> gamma. Register Qsel, G, index.
  - S3: D = R - Qsel + G, computed in DW+2 bits, sign-extended (no intermediate overflow possible).
  - S4: P = D >>> alpha (arithmetic shift, floor toward -inf, e.g. -7>>>1 = -4).
  - S5: S = Qsel + P in DW+3 bits.
    - If S exceeds the signed DW range: ovf=1; qnew = clamp (SAT=1) or S[DW-1:0] (SAT=0).
    - Otherwise ovf=0 and qnew = S[DW-1:0].
- Shift semantics: alpha=0 gives full replacement (Qnew = R + G); gamma=0 gives G = Qmax.
- Qsel, a and amax_out are delayed alongside, so a_out/amax_out match qnew.
- Agents are independent. Identical inputs to all agents give identical outputs.
- Back-to-back samples, bubbles, and gaps in in_valid produce outputs in the same order with identical spacing.

Test Plan:
- Basic, NAG=2, MAX_MODE=0, agent0:
  - Stimulus: q_cur={10,20,30,40}, a=2, q_next={0,100,50,8}, amax=1, r=20, gamma=1, alpha=2, in_valid pulse at cycle 0.
  - Response: at cycle 5, out_valid=1, qnew0=40 (D=20-30+50=40, P=10), a_out0=2, amax_out0=1, ovf0=0.
- Internal argmax, MAX_MODE=1:
  - Stimulus: q_next={5,-3,9,9}, q_cur all 0, a=0, r=0, gamma=0, alpha=0.
  - Response: amax_out=2 (tie -> lowest index), qnew=9.
- Negative rounding:
  - Stimulus: q_cur[a]=0, r=-7, G=0, alpha=1.
  - Response: qnew=-4.
- Saturation, SAT=1, DW=32:
  - Stimulus: Qsel=0x7FFFFF00, r=0x7FFFFFFF, Qmax=0x7FFFFFFF, gamma=0, alpha=0.
  - Response: qnew=0x7FFFFFFF, ovf=1.
  - Same stimulus with SAT=0: qnew = low 32 bits of the sum, ovf=1.
- Streaming:
  - Stimulus: in_valid pattern 1,1,0,1 with distinct r values 1,2,3,4 (r=3 sent while in_valid=0).
  - Response: out_valid pattern 1,1,0,1 starting at cycle 5, qnew in matching order, r=3 sample not emitted.
- Reset mid-flight:
  - Stimulus: 3 samples issued, rst=1 at cycle 2 for one cycle.
  - Response: no out_valid for the dropped samples, all outputs 0 after reset, a new sample after reset emerges 5 cycles later.
